// File: rtl/chess_layout_scanner_if.sv
// ============================================================================
// Module      : chess_layout_scanner_if
// Description : Bundle of the board-scanner signals. The slave modport is the
//               scanner's view (board and flow control in, square stream and
//               frame summary out); the master modport is the view of the
//               block that supplies the board and consumes the square stream.
// Ports       : Layout, ForceScan, SqReady            -> scanner
//               SqValid, SqIdx, SqPiece, SqWhite,
//               SqCursor, SqLocked, SqTarget,
//               FrameStart, FrameEnd, ScanDone, Busy  <- scanner (stream)
//               WhiteCount, BlackCount, WhiteKing,
//               BlackKing, CursorIdx, CursorFound,
//               InvalidSeen                           <- scanner (summary)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chess_layout_scanner_if #(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 8,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
);
  logic [MATRIX_WIDTH-1:0] Layout;
  logic                    ForceScan;
  logic                    SqReady;
  logic                    SqValid;
  logic [5:0]              SqIdx;
  logic [2:0]              SqPiece;
  logic                    SqWhite;
  logic                    SqCursor;
  logic                    SqLocked;
  logic                    SqTarget;
  logic                    FrameStart;
  logic                    FrameEnd;
  logic                    ScanDone;
  logic                    Busy;
  logic [6:0]              WhiteCount;
  logic [6:0]              BlackCount;
  logic                    WhiteKing;
  logic                    BlackKing;
  logic [5:0]              CursorIdx;
  logic                    CursorFound;
  logic                    InvalidSeen;

  modport master (
    output Layout, ForceScan, SqReady,
    input  SqValid, SqIdx, SqPiece, SqWhite, SqCursor, SqLocked, SqTarget,
           FrameStart, FrameEnd, ScanDone, Busy,
           WhiteCount, BlackCount, WhiteKing, BlackKing,
           CursorIdx, CursorFound, InvalidSeen
  );

  modport slave (
    input  Layout, ForceScan, SqReady,
    output SqValid, SqIdx, SqPiece, SqWhite, SqCursor, SqLocked, SqTarget,
           FrameStart, FrameEnd, ScanDone, Busy,
           WhiteCount, BlackCount, WhiteKing, BlackKing,
           CursorIdx, CursorFound, InvalidSeen
  );
endinterface

`default_nettype wire

// File: rtl/chess_layout_scanner.sv
// ============================================================================
// Module      : chess_layout_scanner
// Description : Streams a snapshot of the chess board one square at a time
//               over a valid/ready handshake and, at the end of each frame,
//               publishes piece counts, king presence, the lowest cursor
//               square and an invalid-piece flag.
// Ports       : OutClock  - scan clock, rising edge
//               resetApp  - asynchronous active-high reset
//               bus       - chess_layout_scanner_if.slave (board in, square
//                           stream and frame summary out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chess_layout_scanner #(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 8,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
  input wire logic              OutClock,
  input wire logic              resetApp,
  chess_layout_scanner_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [5:0] LAST_IDX = 6'(CHESS_SQUARES - 1);
  localparam logic [2:0] PC_KING  = 3'd6;
  localparam logic [2:0] PC_BAD   = 3'd7;

  logic [1:0]              state;
  logic [1:0]              stateNext;
  logic [MATRIX_WIDTH-1:0] snapshot;
  logic [5:0]              idx;
  logic                    dirty;

  // Per-frame accumulators, published to the summary registers in DONE.
  logic [6:0] accWhite, accBlack;
  logic       accWKing, accBKing, accCurFound, accInvalid;
  logic [5:0] accCurIdx;

  logic [6:0] sumWhite, sumBlack;
  logic       sumWKing, sumBKing, sumCurFound, sumInvalid;
  logic [5:0] sumCurIdx;

  logic [6:0] curSq;
  logic [2:0] curPiece;
  logic       layoutDiffers;
  logic       startScan;

  // Only the seven meaningful bits of the current square are extracted; the
  // stream is always decoded from the snapshot, never from the live board.
  always_comb curSq = snapshot[32'(idx) * SQUARE_WIDTH +: 7];
  assign curPiece      = curSq[2:0];
  assign layoutDiffers = (bus.Layout != snapshot);
  assign startScan     = (state == ST_IDLE) && (layoutDiffers || bus.ForceScan || dirty);

  // State register
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) state <= ST_IDLE;
    else          state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (startScan) stateNext = ST_SCAN;
      ST_SCAN: if (bus.SqReady && (idx == LAST_IDX)) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.SqValid    = (state == ST_SCAN);
    bus.ScanDone   = (state == ST_DONE);
    bus.Busy       = (state == ST_SCAN) || (state == ST_DONE);
    bus.FrameStart = (state == ST_SCAN) && (idx == 6'd0);
    bus.FrameEnd   = (state == ST_SCAN) && (idx == LAST_IDX);
    bus.SqIdx      = idx;
    bus.SqPiece    = curPiece;
    bus.SqWhite    = curSq[3];
    bus.SqCursor   = curSq[4];
    bus.SqLocked   = curSq[5];
    bus.SqTarget   = curSq[6];
  end

  assign bus.WhiteCount  = sumWhite;
  assign bus.BlackCount  = sumBlack;
  assign bus.WhiteKing   = sumWKing;
  assign bus.BlackKing   = sumBKing;
  assign bus.CursorIdx   = sumCurIdx;
  assign bus.CursorFound = sumCurFound;
  assign bus.InvalidSeen = sumInvalid;

  // Snapshot, index, dirty flag, accumulators and summary registers
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      snapshot    <= '0;
      idx         <= '0;
      dirty       <= 1'b0;
      accWhite    <= '0;
      accBlack    <= '0;
      accWKing    <= 1'b0;
      accBKing    <= 1'b0;
      accCurFound <= 1'b0;
      accCurIdx   <= '0;
      accInvalid  <= 1'b0;
      sumWhite    <= '0;
      sumBlack    <= '0;
      sumWKing    <= 1'b0;
      sumBKing    <= 1'b0;
      sumCurFound <= 1'b0;
      sumCurIdx   <= '0;
      sumInvalid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startScan) begin
            snapshot    <= bus.Layout;
            idx         <= '0;
            dirty       <= 1'b0;
            accWhite    <= '0;
            accBlack    <= '0;
            accWKing    <= 1'b0;
            accBKing    <= 1'b0;
            accCurFound <= 1'b0;
            accCurIdx   <= '0;
            accInvalid  <= 1'b0;
          end
        end
        ST_SCAN: begin
          // Remember a board change or rescan request; the frame in flight
          // keeps running on the snapshot.
          if (layoutDiffers || bus.ForceScan) dirty <= 1'b1;
          if (bus.SqReady) begin
            if ((curPiece != 3'd0) && (curPiece != PC_BAD)) begin
              if (curSq[3]) accWhite <= accWhite + 7'd1;
              else          accBlack <= accBlack + 7'd1;
              if (curPiece == PC_KING) begin
                if (curSq[3]) accWKing <= 1'b1;
                else          accBKing <= 1'b1;
              end
            end
            if (curPiece == PC_BAD) accInvalid <= 1'b1;
            if (curSq[4] && !accCurFound) begin
              accCurFound <= 1'b1;
              accCurIdx   <= idx;
            end
            // Index parks on the last square; the next frame reloads it.
            if (idx != LAST_IDX) idx <= idx + 6'd1;
          end
        end
        ST_DONE: begin
          if (layoutDiffers || bus.ForceScan) dirty <= 1'b1;
          sumWhite    <= accWhite;
          sumBlack    <= accBlack;
          sumWKing    <= accWKing;
          sumBKing    <= accBKing;
          sumCurFound <= accCurFound;
          sumCurIdx   <= accCurIdx;
          sumInvalid  <= accInvalid;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
